// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: operand/sum bus between the PC sequencer and the shared
// 16-bit signed adder.
//   master (sequencer): drives add_a, add_b, add_en; receives add_y
//   slave  (adder)    : receives add_a, add_b, add_en; drives add_y
// add_y is a combinational return: it must settle within the same cycle.
interface pc_sequencer_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_en;
    logic [WIDTH-1:0] add_y;

    modport master (output add_a, output add_b, output add_en, input add_y);
    modport slave  (input add_a, input add_b, input add_en, output add_y);
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the RISC-Z core.
// Holds the PC and selects the next PC each enabled cycle: sequential,
// relative branch, absolute jump, call, return or halt. PC+1 and PC+offset
// come from the external adder over the bus interface. A small
// return-address stack backs CALL/RET; a RUN/HALTED/FAULT machine gates
// progress (FAULT is sticky until reset).
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   enable          advance when 1, hold all state when 0
//   op[2:0]         0 SEQ, 1 BR, 2 JMP, 3 CALL, 4 RET, 5 HALT, 6/7 as SEQ
//   cond            BR condition
//   offset, target  signed branch offset / absolute JMP-CALL target
//   resume          leave HALTED
//   bus (master)    adder operands add_a/add_b, add_en, sum add_y
//   pc, sp          registered PC and return-stack occupancy
//   halted, fault   registered state flags
//
// Optional build macro PC_TRACE_EN adds trace_valid / trace_from: a one-cycle
// pulse after each non-sequential PC update, carrying the pre-update PC.
module pc_sequencer #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VEC   = '0,
    parameter int               STACK_DEPTH = 4,
    localparam int              SPW         = $clog2(STACK_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           op,
    input  logic                 cond,
    input  logic [WIDTH-1:0]     offset,
    input  logic [WIDTH-1:0]     target,
    input  logic                 resume,
    pc_sequencer_if.master       bus,
    output logic [WIDTH-1:0]     pc,
    output logic [SPW-1:0]       sp,
    output logic                 halted,
`ifdef PC_TRACE_EN
    output logic                 fault,
    output logic                 trace_valid,
    output logic [WIDTH-1:0]     trace_from
`else
    output logic                 fault
`endif
);

    localparam logic [2:0] OP_SEQ  = 3'd0;
    localparam logic [2:0] OP_BR   = 3'd1;
    localparam logic [2:0] OP_JMP  = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;
    localparam logic [2:0] OP_HALT = 3'd5;

    localparam int               IDXW    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SPW-1:0]   SP_FULL = SPW'(STACK_DEPTH);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_HALTED = 2'd1,
        S_FAULT  = 2'd2
    } state_e;

    state_e           state;
    logic [WIDTH-1:0] stack [STACK_DEPTH];

    logic             full, empty, run_en;
    logic [SPW-1:0]   sp_m1;
    logic [IDXW-1:0]  push_idx, pop_idx;

    assign full     = (sp == SP_FULL);
    assign empty    = (sp == '0);
    assign run_en   = enable && (state == S_RUN);
    assign sp_m1    = sp - SPW'(1);
    // Truncation is safe: pushes only happen below SP_FULL, pops only above 0.
    assign push_idx = sp[IDXW-1:0];
    assign pop_idx  = sp_m1[IDXW-1:0];

    // Adder operands: the same add_y serves PC+1 and PC+offset.
    assign bus.add_a  = pc;
    assign bus.add_b  = (op == OP_BR && cond) ? offset : ONE;
    assign bus.add_en = (state == S_RUN);

    // Return-address storage has no reset; only sp decides what is valid.
    // add_y is pc+1 here because add_b is 1 for every op except taken BR.
    always_ff @(posedge clk) begin
        if (!reset && run_en && op == OP_CALL && !full)
            stack[push_idx] <= bus.add_y;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_VEC;
            sp     <= '0;
            state  <= S_RUN;
            halted <= 1'b0;
            fault  <= 1'b0;
        end else if (enable) begin
            case (state)
                S_RUN: begin
                    case (op)
                        OP_BR:  pc <= bus.add_y;
                        OP_JMP: pc <= target;
                        OP_CALL: begin
                            // Overflow faults with no partial update.
                            if (full) begin
                                state <= S_FAULT;
                                fault <= 1'b1;
                            end else begin
                                sp <= sp + SPW'(1);
                                pc <= target;
                            end
                        end
                        OP_RET: begin
                            if (empty) begin
                                state <= S_FAULT;
                                fault <= 1'b1;
                            end else begin
                                sp <= sp_m1;
                                pc <= stack[pop_idx];
                            end
                        end
                        OP_HALT: begin
                            pc     <= bus.add_y;
                            state  <= S_HALTED;
                            halted <= 1'b1;
                        end
                        default: pc <= bus.add_y;  // SEQ and reserved codes
                    endcase
                end
                S_HALTED: begin
                    if (resume) begin
                        state  <= S_RUN;
                        halted <= 1'b0;
                    end
                end
                default: ;  // FAULT: sticky until reset
            endcase
        end
    end

`ifdef PC_TRACE_EN
    logic xfer;

    // Non-sequential PC update this cycle: taken BR, JMP, good CALL/RET.
    assign xfer = run_en && ((op == OP_BR && cond) || op == OP_JMP ||
                             (op == OP_CALL && !full) || (op == OP_RET && !empty));

    always_ff @(posedge clk) begin
        if (reset) begin
            trace_valid <= 1'b0;
            trace_from  <= '0;
        end else begin
            trace_valid <= xfer;
            if (xfer)
                trace_from <= pc;
        end
    end
`endif

    // OP_SEQ is covered by the default arm; keep the name for readability.
    logic unused_seq;
    assign unused_seq = ^OP_SEQ;

endmodule
